// File: rtl/hqm_mem_reset_seq_pkg.sv
// Shared types and default timing constants for the memory reset sequencer.
package hqm_mem_reset_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ASSERT    = 3'd1,
        RELEASE   = 3'd2,
        INIT_WAIT = 3'd3,
        DONE      = 3'd4
    } rst_seq_state_t;

    localparam int HQM_MEM_RST_HOLD_CYC   = 16;
    localparam int HQM_MEM_RST_SETTLE_CYC = 4;
    localparam int HQM_MEM_RST_INIT_TMO   = 1024;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hqm_mem_ctech_buf.sv
// Technology buffer cell wrapper; keeps scan control nets on a dedicated cell.
module hqm_mem_ctech_buf (
    input  logic a,
    output logic o
);

    assign o = a;

endmodule

// File: rtl/hqm_mem_reset_seq.sv
// Memory reset sequencer: stretched reset pulse, settle window, init-done wait
// with timeout, and a one-cycle completion acknowledge.
module hqm_mem_reset_seq
    import hqm_mem_reset_seq_pkg::*;
#(
    parameter int HOLD_CYC   = HQM_MEM_RST_HOLD_CYC,
    parameter int SETTLE_CYC = HQM_MEM_RST_SETTLE_CYC,
    parameter int INIT_TMO   = HQM_MEM_RST_INIT_TMO
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fscan_rstbypen,
    input  logic fscan_byprst_b,
    input  logic rst_req,
    input  logic mem_init_done,
    output logic mem_rst_n,
    output logic busy,
    output logic rst_ack,
    output logic init_tmo_err
);

    localparam int CNT_W = $clog2(max3(HOLD_CYC, SETTLE_CYC, INIT_TMO)) + 1;

    rst_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_rst_n_q, mem_rst_n_d;
    logic             busy_q, busy_d;
    logic             rst_ack_q, rst_ack_d;
    logic             tmo_err_q, tmo_err_d;
    logic             pend_q, pend_d;
    logic             buf_rstbypen, buf_byprst_b;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        mem_rst_n_d = mem_rst_n_q;
        tmo_err_d   = tmo_err_q;
        // Requests arriving mid-sequence collapse into a single pending flag.
        pend_d      = pend_q | rst_req;
        case (state_q)
            IDLE: begin
                mem_rst_n_d = 1'b1;
                cnt_d       = '0;
                pend_d      = 1'b0;
                if (rst_req || pend_q) begin
                    state_d     = ASSERT;
                    mem_rst_n_d = 1'b0;
                    tmo_err_d   = 1'b0;
                end
            end
            ASSERT: begin
                mem_rst_n_d = 1'b0;
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    state_d     = RELEASE;
                    mem_rst_n_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            RELEASE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = INIT_WAIT;
                    cnt_d   = '0;
                end
            end
            INIT_WAIT: begin
                if (mem_init_done) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(INIT_TMO - 1)) begin
                    state_d   = DONE;
                    tmo_err_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d     = ASSERT;
                mem_rst_n_d = 1'b0;
                cnt_d       = '0;
            end
        endcase
        // Status outputs are registered decodes of the state being entered.
        busy_d    = (state_d != IDLE);
        rst_ack_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ASSERT;
            cnt_q       <= '0;
            mem_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            rst_ack_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_rst_n_q <= mem_rst_n_d;
            busy_q      <= busy_d;
            rst_ack_q   <= rst_ack_d;
            tmo_err_q   <= tmo_err_d;
            pend_q      <= pend_d;
        end
    end

    hqm_mem_ctech_buf u_buf_rstbypen (.a(fscan_rstbypen), .o(buf_rstbypen));
    hqm_mem_ctech_buf u_buf_byprst_b (.a(fscan_byprst_b), .o(buf_byprst_b));

    assign mem_rst_n    = buf_rstbypen ? buf_byprst_b : mem_rst_n_q;
    assign busy         = busy_q;
    assign rst_ack      = rst_ack_q;
    assign init_tmo_err = tmo_err_q;

    a_cnt_no_wrap : assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q != {CNT_W{1'b1}});

endmodule

// File: tb/tb_hqm_mem_reset_seq.sv
// Scoreboard bench for hqm_mem_reset_seq: directed sequences push expected
// acknowledge cycles; a negedge monitor pops and compares on each rst_ack.
module tb_hqm_mem_reset_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fscan_rstbypen = 1'b0;
    logic fscan_byprst_b = 1'b1;
    logic rst_req = 1'b0;
    logic mem_init_done = 1'b0;
    logic mem_rst_n, busy, rst_ack, init_tmo_err;

    hqm_mem_reset_seq dut (
        .clk(clk), .rst_n(rst_n),
        .fscan_rstbypen(fscan_rstbypen), .fscan_byprst_b(fscan_byprst_b),
        .rst_req(rst_req), .mem_init_done(mem_init_done),
        .mem_rst_n(mem_rst_n), .busy(busy), .rst_ack(rst_ack),
        .init_tmo_err(init_tmo_err)
    );

    typedef struct {
        int cyc;
        int tmo;
        bit chk_low;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   acks_seen = 0;
    int   low_cnt = 0;
    int   last_low = 0;
    bit   prev_ack = 1'b0;
    bit   model_en = 1'b1;
    int   lat = 10;
    int   hcnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int t, input bit l);
        exp_t e;
        e.cyc = c; e.tmo = t; e.chk_low = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_acks(input int tgt, input int budget);
        int n = 0;
        while (acks_seen < tgt && n < budget) begin
            step(1);
            n++;
        end
        chk("ack_wait", int'(acks_seen >= tgt), 1);
    endtask

    // Memory model: init completes lat cycles after its reset is released.
    always begin
        @(posedge clk);
        #1;
        if (model_en) begin
            if (!mem_rst_n) begin
                hcnt = 0;
                mem_init_done = 1'b0;
            end else if (hcnt == lat) begin
                mem_init_done = 1'b1;
            end else begin
                hcnt++;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !fscan_rstbypen) begin
            if (!mem_rst_n) low_cnt++;
            else if (low_cnt != 0) begin
                last_low = low_cnt;
                low_cnt = 0;
            end
        end
        if (prev_ack) chk("ack_one_cycle", int'(rst_ack), 0);
        if (rst_ack) begin
            acks_seen++;
            if (exp_q.size() == 0) chk("unexpected_ack", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_tmo_err", int'(init_tmo_err), e.tmo);
                chk("ack_busy", int'(busy), 1);
                if (e.chk_low) chk("hold_len", last_low, 16);
            end
        end
        prev_ack = rst_ack;
    end

    initial begin
        int n, p;
        // Power-on reset
        step(3);
        chk("rst_mem_rst_n", int'(mem_rst_n), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_ack", int'(rst_ack), 0);
        chk("rst_tmo_err", int'(init_tmo_err), 0);
        step(2);
        lat = 10;
        rst_n = 1'b1;
        p = cyc;
        push(p + 27, 0, 1);
        wait_acks(1, 100);
        step(5);
        chk("por_idle_busy", int'(busy), 0);
        chk("por_idle_mem_rst_n", int'(mem_rst_n), 1);

        // Single-cycle functional request
        lat = 8;
        n = cyc;
        rst_req = 1'b1;
        push(n + 26, 0, 1);
        step(1);
        rst_req = 1'b0;
        chk("req_latency_mem_rst_n", int'(mem_rst_n), 0);
        chk("req_latency_busy", int'(busy), 1);
        wait_acks(2, 100);

        // Init timeout, then sticky error cleared by the next sequence
        step(3);
        lat = 1000000;
        n = cyc;
        rst_req = 1'b1;
        push(n + 1045, 1, 1);
        step(1);
        rst_req = 1'b0;
        wait_acks(3, 1200);
        step(2);
        chk("tmo_err_sticky", int'(init_tmo_err), 1);
        lat = 3;
        n = cyc;
        rst_req = 1'b1;
        push(n + 22, 0, 1);
        step(1);
        rst_req = 1'b0;
        chk("tmo_err_clear", int'(init_tmo_err), 0);
        wait_acks(4, 100);

        // Requests while busy collapse into one extra sequence
        step(3);
        lat = 5;
        n = cyc;
        rst_req = 1'b1;
        push(n + 23, 0, 1);
        push(n + 47, 0, 1);
        step(1);  rst_req = 1'b0;
        step(2);  rst_req = 1'b1;
        step(1);  rst_req = 1'b0;
        step(4);  rst_req = 1'b1;
        step(1);  rst_req = 1'b0;
        step(12); rst_req = 1'b1;
        step(1);  rst_req = 1'b0;
        wait_acks(6, 100);
        step(30);
        chk("pend_no_third_busy", int'(busy), 0);
        chk("pend_ack_count", acks_seen, 6);

        // Asynchronous reset during INIT_WAIT
        step(3);
        lat = 20;
        n = cyc;
        rst_req = 1'b1;
        step(1);
        rst_req = 1'b0;
        step(24);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_rst_n", int'(mem_rst_n), 0);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_ack", int'(rst_ack), 0);
        step(3);
        rst_n = 1'b1;
        p = cyc;
        push(p + 37, 0, 1);
        wait_acks(7, 100);

        // Scan bypass follows fscan_byprst_b in every state
        step(3);
        model_en = 1'b0;
        mem_init_done = 1'b0;
        fscan_rstbypen = 1'b1;
        fscan_byprst_b = 1'b0;
        #1;
        chk("byp_idle", int'(mem_rst_n), 0);
        step(1);
        n = cyc;
        rst_req = 1'b1;
        push(n + 22, 0, 0);
        step(1);
        rst_req = 1'b0;
        step(4);
        fscan_byprst_b = 1'b1;
        #1;
        chk("byp_assert", int'(mem_rst_n), 1);
        step(13);
        fscan_byprst_b = 1'b0;
        #1;
        chk("byp_release", int'(mem_rst_n), 0);
        step(3);
        chk("byp_init_wait", int'(mem_rst_n), 0);
        mem_init_done = 1'b1;
        step(1);
        mem_init_done = 1'b0;
        wait_acks(8, 50);
        fscan_rstbypen = 1'b0;
        fscan_byprst_b = 1'b1;
        step(2);
        chk("byp_off_mem_rst_n", int'(mem_rst_n), 1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
